wrapper: RTL and testbench
==========================

# wrapper

Top-level demo block for the board: reads the 16 DIP switches and the push-buttons, runs one iterative 16-bit multiply or divide against a fixed constant, and shows the result on the 32-bit seven-segment bus. It runs continuously; each operation re-samples the inputs. LED_PC shows a count of completed operations. It sits directly under the board top, between the I/O pins and the display driver.

## Interface
- N_LEDs_OUT, 8: width reserved for general LEDs; no port uses it in this block.
- N_DIPs, 16: DIP switch width and operand width.
- N_PBs, 3: push-button count.
- MUL_CONST, 16'h00CC: multiplier constant.
- DIV_CONST, 16'h00BB: divisor constant.
- CLK  in  1  single clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-low reset. RESET=0 sampled at a CLK edge resets the block.
- DIP  in  N_DIPs  operand A, unsigned.
- PB  in  N_PBs  PB[1]=1 selects MUL, PB[1]=0 selects DIV. PB[0] and PB[2] are ignored.
- LED_PC  out  7  completed-operation count, modulo 128.
- SEVENSEGHEX  out  32  last completed result.

## Operation
- DIP and PB each pass through a 2-flop synchronizer before use.
- State machine, four states:
  - IDLE: always moves to SAMPLE on the next cycle.
  - SAMPLE: latch synchronized DIP as A and PB[1] as op, clear the iteration counter, go to BUSY.
  - BUSY: exactly 16 iterations, one per cycle, then go to WRITE.
  - WRITE: update SEVENSEGHEX, increment LED_PC, go to SAMPLE.
- MUL: radix-2 shift-add. SEVENSEGHEX = A × MUL_CONST as a full 32-bit unsigned product. No overflow is possible.
- DIV: restoring division with a 16-bit quotient Q and a 16-bit remainder R.
  - SEVENSEGHEX = {Q, R}.
  - If DIV_CONST = 0: Q = 16'hFFFF and R = A.
- A = 0 gives result 0 for both operations.
- Inputs that change during BUSY do not affect the operation in flight. They are picked up at the next SAMPLE.
- LED_PC wraps from 127 to 0.

## Timing
- Reset values: SEVENSEGHEX = 0, LED_PC = 0, state = IDLE, synchronizers cleared.
- After RESET deasserts: IDLE for 1 cycle, then SAMPLE.
- Operation period is 18 cycles: SAMPLE 1 + BUSY 16 + WRITE 1.
- SEVENSEGHEX and LED_PC change on the edge that leaves WRITE. They are stable for the other 17 cycles of the period.
- Input-to-sample latency: a DIP or PB value must be stable for the 2 cycles before the SAMPLE edge to be used.
- Reset mid-operation: the operation is aborted, outputs return to 0, and no partial result is ever shown.
- A worst-case change takes at most 2 + 18 + 18 = 38 cycles to appear on SEVENSEGHEX.

## Configuration
- WRAPPER_DIV_EN defined: divider datapath present, and PB[1] selects between MUL and DIV as above.
- WRAPPER_DIV_EN undefined:
  - Divider logic is removed.
  - Every operation is MUL regardless of PB.
  - Timing is unchanged at an 18-cycle period.

## Structure
- Package wrapper_pkg holds:
  - the state enum (IDLE, SAMPLE, BUSY, WRITE) and the op enum (OP_MUL, OP_DIV);
  - ITER_COUNT = 16;
  - the default MUL_CONST and DIV_CONST.
- Sub-module wrapper_muldiv holds the iterative unit.
  - Inputs: start, op, a, b.
  - Outputs: busy, done, result[31:0].
  - It contains the shared 32-bit accumulator and shift register.
- The wrapper itself holds the synchronizers, the FSM and the output registers.

## Test plan
- Reset: hold RESET=0 for 3 cycles -> SEVENSEGHEX=0, LED_PC=0. Release RESET -> first result at cycle 1+18 after release.
- MUL: PB=3'b010, DIP=16'h05DB -> SEVENSEGHEX=32'h0004AA84. Then DIP=0 -> SEVENSEGHEX=0 within 38 cycles.
- DIV: PB=3'b000, DIP=16'h05DB -> SEVENSEGHEX=32'h00080003 (8 R 3). DIP=0 -> 32'h00000000. DIP=16'h00AA -> 32'h000000AA.
- Input change mid-operation: switch DIP from 16'h05DB to 0 during BUSY with MUL selected -> the current result is still 32'h0004AA84; the next result is 0.
- Counter: run 130 operations -> LED_PC wraps from 7'd127 to 0 and reads 2. Pulse RESET low mid-BUSY -> outputs 0 on the next edge.
- Build without WRAPPER_DIV_EN: PB=3'b000, DIP=16'h05DB -> SEVENSEGHEX=32'h0004AA84.

Source files
------------

// File: rtl/wrapper_pkg.sv
// wrapper_pkg: shared FSM/op enums, iteration count and default operand constants for wrapper
package wrapper_pkg;
  typedef enum logic [1:0] {IDLE, SAMPLE, BUSY, WRITE} state_t;
  typedef enum logic {OP_MUL, OP_DIV} op_t;
  localparam int ITER_COUNT = 16;
  localparam logic [15:0] DEF_MUL_CONST = 16'h00CC;
  localparam logic [15:0] DEF_DIV_CONST = 16'h00BB;
endpackage

// File: rtl/wrapper_muldiv.sv
// wrapper_muldiv: 16-iteration shift-add multiplier / restoring divider (divider only with WRAPPER_DIV_EN)
module wrapper_muldiv
  import wrapper_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  op_t         op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam int CW = $clog2(ITER_COUNT);
  logic [31:0] acc, acc_nx, mul_acc;
  logic [15:0] sh, sh_nx, b_q;
  logic [CW-1:0] cnt;
  assign done = busy && cnt == CW'(ITER_COUNT - 1);
  // MSB-first: both operations shift the operand out of sh into acc
  assign mul_acc = {acc[30:0], 1'b0} + (sh[15] ? {16'h0, b_q} : 32'h0);
`ifdef WRAPPER_DIV_EN
  op_t op_q;
  logic [16:0] rem;
  logic [15:0] rem_sub;
  logic qbit;
  // b = 0 always sets qbit and leaves rem untouched, giving Q = FFFF and R = a
  assign rem = {acc[15:0], sh[15]};
  assign qbit = rem >= {1'b0, b_q};
  assign rem_sub = qbit ? rem[15:0] - b_q : rem[15:0];
  assign acc_nx = op_q == OP_DIV ? {16'h0, rem_sub} : mul_acc;
  assign sh_nx = {sh[14:0], op_q == OP_DIV ? qbit : 1'b0};
  assign result = op_q == OP_DIV ? {sh, acc[15:0]} : acc;
  always_ff @(posedge clk)
    if (!rst_n) op_q <= OP_MUL;
    else if (start) op_q <= op;
`else
  logic unused_op;
  assign unused_op = op;
  assign acc_nx = mul_acc;
  assign sh_nx = {sh[14:0], 1'b0};
  assign result = acc;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      acc <= '0;
      sh <= '0;
      b_q <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      acc <= '0;
      sh <= a;
      b_q <= b;
    end else if (busy) begin
      busy <= !done;
      cnt <= cnt + CW'(1);
      acc <= acc_nx;
      sh <= sh_nx;
    end
endmodule

// File: rtl/wrapper.sv
// wrapper: DIP/PB synchronizers, 18-cycle sample/compute/write FSM and display registers; WRAPPER_DIV_EN enables DIV via PB[1]=0
module wrapper
  import wrapper_pkg::*;
#(
  parameter int N_LEDs_OUT = 8,
  parameter int N_DIPs = 16,
  parameter int N_PBs = 3,
  parameter logic [15:0] MUL_CONST = DEF_MUL_CONST,
  parameter logic [15:0] DIV_CONST = DEF_DIV_CONST
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_DIPs-1:0] DIP,
  input  logic [N_PBs-1:0]  PB,
  output logic [6:0]        LED_PC,
  output logic [31:0]       SEVENSEGHEX
);
  state_t state, state_nx;
  logic [N_DIPs-1:0] dip_s1, dip_s2;
  logic [N_PBs-1:0] pb_s1, pb_s2;
  logic start, wr, md_busy, md_done, unused_ok;
  logic [31:0] md_result;
  op_t op;
`ifdef WRAPPER_DIV_EN
  assign op = pb_s2[1] ? OP_MUL : OP_DIV;
`else
  assign op = OP_MUL;
`endif
  assign unused_ok = ^{pb_s2, md_busy, N_LEDs_OUT > 0};
  always_ff @(posedge CLK)
    if (!RESET) begin
      dip_s1 <= '0;
      dip_s2 <= '0;
      pb_s1 <= '0;
      pb_s2 <= '0;
    end else begin
      dip_s1 <= DIP;
      dip_s2 <= dip_s1;
      pb_s1 <= PB;
      pb_s2 <= pb_s1;
    end
  always_ff @(posedge CLK)
    state <= !RESET ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE   ? SAMPLE :
               state == SAMPLE ? BUSY :
               state == BUSY   ? (md_done ? WRITE : BUSY) : SAMPLE;
  always_comb begin
    start = state == SAMPLE;
    wr = state == WRITE;
  end
  always_ff @(posedge CLK)
    if (!RESET) begin
      SEVENSEGHEX <= '0;
      LED_PC <= '0;
    end else if (wr) begin
      SEVENSEGHEX <= md_result;
      LED_PC <= LED_PC + 7'd1;
    end
  wrapper_muldiv u_muldiv (
    .clk    (CLK),
    .rst_n  (RESET),
    .start  (start),
    .op     (op),
    .a      (dip_s2),
    .b      (op == OP_DIV ? DIV_CONST : MUL_CONST),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );
endmodule

// File: tb/tb_wrapper.sv
// tb_wrapper: directed self-checking bench for wrapper (expectations follow WRAPPER_DIV_EN)
module tb_wrapper;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] dip;
  logic [2:0] pb;
  logic [6:0] led_pc;
  logic [31:0] seg;
  int n_chk = 0;
  int n_pass = 0;
`ifdef WRAPPER_DIV_EN
  localparam logic [31:0] E_D5DB = 32'h00080003, E_DAA = 32'h000000AA, E_DFFFF = 32'h015E0055;
`else
  localparam logic [31:0] E_D5DB = 32'h0004AA84, E_DAA = 32'h00008778, E_DFFFF = 32'h00CBFF34;
`endif
  always #5 clk = ~clk;
  wrapper dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .DIP         (dip),
    .PB          (pb),
    .LED_PC      (led_pc),
    .SEVENSEGHEX (seg)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask
  task automatic wait_write(output int cyc);
    logic [6:0] led0;
    led0 = led_pc;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (led_pc == led0 && cyc < 40);
    check("write_seen", 32'(led_pc != led0), 32'd1);
  endtask
  task automatic apply(input string tag, input logic [15:0] d, input logic [2:0] p, input logic [31:0] exp);
    int c1, c2;
    dip = d;
    pb = p;
    wait_write(c1);
    wait_write(c2);
    check(tag, seg, exp);
    check({tag, "_lat"}, 32'(c1 + c2 <= 38), 32'd1);
  endtask
  initial begin
    int c;
    rst_n = 1'b0;
    dip = 16'h05DB;
    pb = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", seg, 32'h0);
    check("rst_led", 32'(led_pc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_write(c);
    check("first_lat", 32'(c), 32'd19);
    check("first_res", seg, 32'h0);
    wait_write(c);
    check("mul_5db", seg, 32'h0004AA84);
    check("led_2", 32'(led_pc), 32'd2);
    repeat (3) @(posedge clk);
    #1;
    dip = 16'h0000;
    check("hold", seg, 32'h0004AA84);
    wait_write(c);
    check("mid_cur", seg, 32'h0004AA84);
    wait_write(c);
    check("mid_next", seg, 32'h0);
    apply("div_5db", 16'h05DB, 3'b000, E_D5DB);
    apply("div_0", 16'h0000, 3'b000, 32'h0);
    apply("div_aa", 16'h00AA, 3'b000, E_DAA);
    apply("mul_ffff", 16'hFFFF, 3'b010, 32'h00CBFF34);
    apply("div_ffff", 16'hFFFF, 3'b101, E_DFFFF);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_led", 32'(led_pc), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      wait_write(c);
      if (i == 127 || i == 128 || i == 130) check($sformatf("led_%0d", i), 32'(led_pc), 32'(i % 128));
    end
    check("pre_rst_seg", 32'(seg != 0), 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midbusy_seg", seg, 32'h0);
    check("midbusy_led", 32'(led_pc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_write(c);
    check("post_rst_lat", 32'(c), 32'd19);
    check("post_rst_res", seg, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
